// File: rtl/fhu_pkg.sv
// Shared definitions for the forwarding/hazard unit: default geometry,
// bypass-select encodings and the scoreboard entry layout.
package fhu_pkg;

    localparam int REG_W_DEF      = 5;
    localparam int NUM_STAGES_DEF = 2;
    localparam int LOAD_READY_DEF = 2;
    localparam int MD_LATENCY_DEF = 32;

    // Bypass selects: 0 is the register file, k is producer stage k,
    // all-ones is the mult/div result.
    localparam int SEL_RF = 0;

    // One scoreboard slot (default register width).
    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] rd;
        logic                 is_load;
    } sb_entry_t;

    // Select width must hold 0, every stage index and the all-ones MD code.
    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 2);
    endfunction

endpackage

// File: rtl/fhu_operand_match.sv
// Per-operand bypass selection: finds the youngest in-flight producer of
// one source register and reports load-use and mult/div hazards on it.
module fhu_operand_match
    import fhu_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int SEL_W      = sel_width(NUM_STAGES_DEF)
) (
    input  logic [REG_W-1:0]                  src,
    input  logic [NUM_STAGES:1]               sb_valid,
    input  logic [NUM_STAGES:1]               sb_load,
    input  logic [NUM_STAGES:1][REG_W-1:0]    sb_rd,
    input  logic                              md_busy,
    input  logic                              md_done,
    input  logic [REG_W-1:0]                  md_rd,
    output logic [SEL_W-1:0]                  sel,
    output logic                              load_hazard,
    output logic                              md_hazard
);

    localparam logic [SEL_W-1:0] SEL_MD = '1;

    logic [SEL_W-1:0] sb_sel_s;
    logic             sb_load_hz_s;
    logic             md_match_s;

    // Walk oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        sb_sel_s     = SEL_W'(SEL_RF);
        sb_load_hz_s = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            sb_load_hz_s = (sb_valid[k] && (sb_rd[k] == src) && (src != '0))
                           ? (sb_load[k] && (k < LOAD_READY)) : sb_load_hz_s;
            sb_sel_s     = (sb_valid[k] && (sb_rd[k] == src) && (src != '0))
                           ? ((sb_load[k] && (k < LOAD_READY)) ? SEL_W'(SEL_RF) : SEL_W'(k))
                           : sb_sel_s;
        end
    end

    // A pending mult/div result on this register overrides the scoreboard choice.
    always_comb begin
        md_match_s = md_busy && (md_rd == src) && (src != '0);
        if (md_match_s && md_done) begin
            sel         = SEL_MD;
            load_hazard = 1'b0;
            md_hazard   = 1'b0;
        end else if (md_match_s) begin
            sel         = SEL_W'(SEL_RF);
            load_hazard = sb_load_hz_s;
            md_hazard   = 1'b1;
        end else begin
            sel         = sb_sel_s;
            load_hazard = sb_load_hz_s;
            md_hazard   = 1'b0;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and interlock unit beside the DX latch.
// Keeps a shift scoreboard of in-flight destination registers, picks the
// bypass source per operand and raises the pipeline stall.
// Optional feature: define MULTDIV_EN to track a multi-cycle mult/div unit.
module forward_hazard_unit
    import fhu_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    localparam int SEL_W     = sel_width(NUM_STAGES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dx_valid,
    input  logic [REG_W-1:0] dx_src1,
    input  logic [REG_W-1:0] dx_src2,
    input  logic             dx_we,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_is_load,
    input  logic             dx_is_md,
    input  logic             flush,
    output logic [SEL_W-1:0] bypass_a,
    output logic [SEL_W-1:0] bypass_b,
    output logic             stall,
    output logic             md_busy
);

    logic [NUM_STAGES:1]            sb_valid_r;
    logic [NUM_STAGES:1]            sb_load_r;
    logic [NUM_STAGES:1][REG_W-1:0] sb_rd_r;

    logic             push_s;
    logic             stall_s;
    logic             load_hz_a_s, load_hz_b_s;
    logic             md_hz_a_s, md_hz_b_s;
    logic             md_busy_s, md_done_s;
    logic             md_struct_hz_s;
    logic [REG_W-1:0] md_rd_s;
    logic             dx_md_op_s;

`ifdef MULTDIV_EN
    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] md_cnt_r;
    logic [REG_W-1:0] md_rd_r;
    logic             md_busy_r;
    logic             md_issue_s;

    assign md_busy_s  = md_busy_r;
    assign md_done_s  = md_busy_r && (md_cnt_r == CNT_W'(1));
    assign md_rd_s    = md_rd_r;
    assign dx_md_op_s = dx_is_md;
    assign md_issue_s = dx_is_md && dx_valid && !stall_s && !flush;

    // Issue of a second mult/div or a write to the pending register must wait for the done cycle.
    always_comb begin
        if (md_busy_r && !md_done_s) begin
            md_struct_hz_s = dx_is_md ||
                             (dx_we && (dx_rd == md_rd_r) && (dx_rd != '0));
        end else begin
            md_struct_hz_s = 1'b0;
        end
    end

    // Mult/div countdown: load on issue, count down, release after the done cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_cnt_r  <= '0;
            md_rd_r   <= '0;
            md_busy_r <= 1'b0;
        end else if (md_issue_s) begin
            md_cnt_r  <= CNT_W'(MD_LATENCY);
            md_rd_r   <= dx_we ? dx_rd : '0;
            md_busy_r <= 1'b1;
        end else begin
            md_cnt_r  <= (md_cnt_r != '0) ? md_cnt_r - CNT_W'(1) : md_cnt_r;
            md_rd_r   <= md_rd_r;
            md_busy_r <= md_busy_r && !md_done_s;
        end
    end
`else
    localparam int unused_md_latency = MD_LATENCY;
    logic unused_md_s;

    assign unused_md_s    = dx_is_md;
    assign md_busy_s      = 1'b0;
    assign md_done_s      = 1'b0;
    assign md_rd_s        = '0;
    assign dx_md_op_s     = 1'b0;
    assign md_struct_hz_s = 1'b0;
`endif

    fhu_operand_match #(
        .REG_W      (REG_W),
        .NUM_STAGES (NUM_STAGES),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_a (
        .src         (dx_src1),
        .sb_valid    (sb_valid_r),
        .sb_load     (sb_load_r),
        .sb_rd       (sb_rd_r),
        .md_busy     (md_busy_s),
        .md_done     (md_done_s),
        .md_rd       (md_rd_s),
        .sel         (bypass_a),
        .load_hazard (load_hz_a_s),
        .md_hazard   (md_hz_a_s)
    );

    fhu_operand_match #(
        .REG_W      (REG_W),
        .NUM_STAGES (NUM_STAGES),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
    ) u_match_b (
        .src         (dx_src2),
        .sb_valid    (sb_valid_r),
        .sb_load     (sb_load_r),
        .sb_rd       (sb_rd_r),
        .md_busy     (md_busy_s),
        .md_done     (md_done_s),
        .md_rd       (md_rd_s),
        .sel         (bypass_b),
        .load_hazard (load_hz_b_s),
        .md_hazard   (md_hz_b_s)
    );

    // Stall only for a live, unflushed DX instruction; decides whether DX enters the scoreboard.
    always_comb begin
        if (dx_valid && !flush) begin
            stall_s = load_hz_a_s || load_hz_b_s || md_hz_a_s || md_hz_b_s || md_struct_hz_s;
            push_s  = dx_we && !stall_s && !dx_md_op_s;
        end else begin
            stall_s = 1'b0;
            push_s  = 1'b0;
        end
    end

    assign stall   = stall_s;
    assign md_busy = md_busy_s;

    // Scoreboard shift: always advances; a stalled, flushed or non-writing DX inserts a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_valid_r <= '0;
            sb_load_r  <= '0;
            sb_rd_r    <= '0;
        end else begin
            sb_valid_r[1] <= push_s;
            sb_load_r[1]  <= push_s && dx_is_load;
            sb_rd_r[1]    <= push_s ? dx_rd : '0;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                sb_valid_r[k] <= sb_valid_r[k-1];
                sb_load_r[k]  <= sb_load_r[k-1];
                sb_rd_r[k]    <= sb_rd_r[k-1];
            end
        end
    end

endmodule
